i2c_sram_master: RTL

Synthesizable single-master I2C controller that sequences complete 16-bit word transactions against `i2c_sram_embedded` on the shared SDA/SCL pair. It accepts one request at a time over a req/ready handshake, generates START, the 7-bit device address plus mode bit, the 8-bit memory address, two data bytes with ACK/NACK slots, and STOP. It returns read data and an ACK-error flag. It replaces the bit-banged master sequences used in the SRAM benches with a clocked block that sits between system logic and the SRAM slave.

---
 rtl/i2c_sram_master.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/i2c_sram_master.sv
// Single-master I2C controller: issues START, device address + mode, memory
// address, two data bytes with ACK slots, and STOP for 16-bit SRAM word transfers.
module i2c_sram_master #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        rw,
  input  logic [6:0]  dev_addr,
  input  logic [7:0]  mem_addr,
  input  logic [15:0] wdata,
  output logic        ready,
  output logic        done,
  output logic        ack_err,
  output logic [15:0] rdata,
  output logic        scl,
  output logic        sda_oe,
  input  logic        sda_in
);
  localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [QW-1:0] Q_LAST = QW'(CLK_DIV - 1);

  // Encoding order matters: byte states advance to their ACK state with +1.
  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_START   = 4'd1;
  localparam logic [3:0] S_ADDR    = 4'd2;
  localparam logic [3:0] S_ACK_A   = 4'd3;
  localparam logic [3:0] S_MADDR   = 4'd4;
  localparam logic [3:0] S_ACK_M   = 4'd5;
  localparam logic [3:0] S_DATA_HI = 4'd6;
  localparam logic [3:0] S_ACK_HI  = 4'd7;
  localparam logic [3:0] S_DATA_LO = 4'd8;
  localparam logic [3:0] S_ACK_LO  = 4'd9;
  localparam logic [3:0] S_STOP    = 4'd10;
  localparam logic [3:0] S_DONE    = 4'd11;

  logic [3:0]    state;
  logic [QW-1:0] qcnt;
  logic [1:0]    q;
  logic [2:0]    bit_cnt;
  logic          rw_l;
  logic [7:0]    maddr_l;
  logic [15:0]   wdata_l;
  logic [7:0]    tx_sr;
  logic [7:0]    rx_sr;
  logic [7:0]    hi_byte;
  logic          sda_smp;
  logic          err;
  logic          slot_end;
  logic          sample_pt;
  logic          slave_ack;

  assign slot_end  = (q == 2'd3) && (qcnt == Q_LAST);
  assign sample_pt = (q == 2'd2) && (qcnt == Q_LAST);
  assign slave_ack = (state == S_ACK_A) || (state == S_ACK_M) ||
                     (!rw_l && ((state == S_ACK_HI) || (state == S_ACK_LO)));
  assign ready     = (state == S_IDLE);

  // Bus levels are a pure decode of slot state, so reset releases the bus at once.
  always_comb begin
    scl    = 1'b1;
    sda_oe = 1'b0;
    case (state)
      S_START:              sda_oe = q[1];
      S_STOP: begin
        scl    = q[1];
        sda_oe = (q != 2'd3);
      end
      S_ADDR, S_MADDR: begin
        scl    = q[1];
        sda_oe = ~tx_sr[bit_cnt];
      end
      S_DATA_HI, S_DATA_LO: begin
        scl    = q[1];
        sda_oe = ~rw_l & ~tx_sr[bit_cnt];
      end
      S_ACK_A, S_ACK_M, S_ACK_LO: scl = q[1];
      S_ACK_HI: begin
        scl    = q[1];
        sda_oe = rw_l;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      qcnt    <= '0;
      q       <= 2'd0;
      bit_cnt <= 3'd7;
      rw_l    <= 1'b0;
      maddr_l <= 8'd0;
      wdata_l <= 16'd0;
      tx_sr   <= 8'd0;
      rx_sr   <= 8'd0;
      hi_byte <= 8'd0;
      sda_smp <= 1'b0;
      err     <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
      rdata   <= 16'd0;
    end else begin
      done <= 1'b0;
      if (sample_pt) begin
        sda_smp <= sda_in;
        if (rw_l && ((state == S_DATA_HI) || (state == S_DATA_LO)))
          rx_sr <= {rx_sr[6:0], sda_in};
      end
      if ((state != S_IDLE) && (state != S_DONE)) begin
        if (qcnt == Q_LAST) begin
          qcnt <= '0;
          q    <= q + 2'd1;
        end else begin
          qcnt <= qcnt + 1'b1;
        end
      end
      case (state)
        S_IDLE: if (req) begin
          rw_l    <= rw;
          maddr_l <= mem_addr;
          wdata_l <= wdata;
          tx_sr   <= {dev_addr, rw};
          bit_cnt <= 3'd7;
          err     <= 1'b0;
          qcnt    <= '0;
          q       <= 2'd0;
          state   <= S_START;
        end
        S_START: if (slot_end) state <= S_ADDR;
        // bit_cnt wraps 0 -> 7, so it is already primed for the next byte.
        S_ADDR, S_MADDR, S_DATA_HI, S_DATA_LO: if (slot_end) begin
          bit_cnt <= bit_cnt - 3'd1;
          if (bit_cnt == 3'd0) state <= state + 4'd1;
        end
        S_ACK_A, S_ACK_M, S_ACK_HI, S_ACK_LO: if (slot_end) begin
          if (slave_ack && sda_smp) begin
            err   <= 1'b1;
            state <= S_STOP;
          end else begin
            state <= state + 4'd1;
            if (state == S_ACK_A) tx_sr <= maddr_l;
            else if (state == S_ACK_M) tx_sr <= wdata_l[15:8];
            else if (state == S_ACK_HI) begin
              tx_sr   <= wdata_l[7:0];
              hi_byte <= rx_sr;
            end
          end
        end
        S_STOP: if (slot_end) state <= S_DONE;
        S_DONE: begin
          done    <= 1'b1;
          ack_err <= err;
          if (rw_l && !err) rdata <= {hi_byte, rx_sr};
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
